// File: rtl/gate_pkg.sv
// Shared definitions for the 2-input gate exerciser: op encoding,
// FSM state encoding and the number of truth-table vectors.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  localparam int NUM_VEC = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_FINISH = 2'd2
  } gate_state_e;

  // Codes 6 and 7 name no gate.
  function automatic logic op_is_legal(input logic [2:0] op_v);
    return (op_v <= OP_XNOR);
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the 2-input gate library: expected y for
// a given op and input pair. Illegal ops yield 0.
module gate_ref_model
  import gate_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y_exp
);

  // Truth-table lookup for the selected gate.
  always_comb begin
    y_exp = 1'b0;
    case (op)
      OP_AND:  y_exp = a & b;
      OP_OR:   y_exp = a | b;
      OP_NAND: y_exp = ~(a & b);
      OP_NOR:  y_exp = ~(a | b);
      OP_XOR:  y_exp = a ^ b;
      OP_XNOR: y_exp = ~(a ^ b);
      default: y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_exerciser.sv
// Truth-table driver/checker for an attached 2-input gate. On start it
// drives {a,b} = 0..3, holding each vector SETTLE cycles, samples y at the
// end of each hold and compares it with the reference model.
//
// Handshake: start is a level request sampled only in IDLE; a request seen
// in any other state (including the FINISH cycle) is dropped, never queued.
// done is a one-cycle pulse; pass/bad_op/err_count/err_mask hold their
// values until the next accepted start. busy covers the accepted sweep.
module gate_exerciser
  import gate_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       bad_op,
  output logic [2:0] err_count,
  output logic [3:0] err_mask,
  output logic [1:0] state_dbg
);

  localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [1:0]    VEC_LAST = 2'(NUM_VEC - 1);

  gate_state_e   state_q;
  logic [2:0]    op_q;
  logic [1:0]    vec_q;     // current vector index k; drives {a,b}
  logic [CW-1:0] cnt_q;     // cycles spent on the current vector
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic          bad_op_q;
  logic [2:0]    err_count_q;
  logic [3:0]    err_mask_q;

  logic          y_exp;
  logic          mismatch;
  logic [2:0]    err_count_d;

  // Expected value follows the registered stimulus, so it lines up with y.
  gate_ref_model u_ref (
    .op    (op_q),
    .a     (vec_q[1]),
    .b     (vec_q[0]),
    .y_exp (y_exp)
  );

  // Mismatch flag and error count including the current sample.
  always_comb begin
    mismatch    = (y != y_exp);
    err_count_d = err_count_q + {2'b00, mismatch};
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_AND;
      vec_q       <= 2'd0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      bad_op_q    <= 1'b0;
      err_count_q <= 3'd0;
      err_mask_q  <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          vec_q  <= 2'd0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            err_count_q <= 3'd0;
            err_mask_q  <= 4'd0;
            pass_q      <= 1'b0;
            if (op_is_legal(op)) begin
              op_q     <= op;
              bad_op_q <= 1'b0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= ST_DRIVE;
            end else begin
              // Nothing to drive: report straight away.
              bad_op_q <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= ST_FINISH;
            end
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            err_count_q <= err_count_d;
            if (mismatch) begin
              err_mask_q[vec_q] <= 1'b1;
            end
            if (vec_q == VEC_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_count_d == 3'd0);
              state_q <= ST_FINISH;
            end else begin
              vec_q <= vec_q + 2'd1;
              cnt_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b0;
          vec_q   <= 2'd0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign a         = vec_q[1];
  assign b         = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign bad_op    = bad_op_q;
  assign err_count = err_count_q;
  assign err_mask  = err_mask_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: two instances (SETTLE=1 and SETTLE=3)
// each driving a bench-side gate whose function is selected per test.
module tb_gate_exerciser;

  localparam int G_AND  = 0;
  localparam int G_OR   = 1;
  localparam int G_NAND = 2;
  localparam int G_NOR  = 3;
  localparam int G_XOR  = 4;
  localparam int G_XNOR = 5;
  localparam int G_ZERO = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus / DUT wiring ----------------
  logic       use3 = 1'b0;
  logic       start_v = 1'b0;
  logic [2:0] op_v = 3'd0;
  int         gmode = G_AND;

  logic       start1, start3;
  logic       a1, b1, y1, busy1, done1, pass1, bad1;
  logic       a3, b3, y3, busy3, done3, pass3, bad3;
  logic [2:0] cnt1, cnt3;
  logic [3:0] mask1, mask3;
  logic [1:0] st1, st3;

  assign start1 = start_v & ~use3;
  assign start3 = start_v & use3;

  function automatic logic gate_out(input int m, input logic ga, input logic gb);
    case (m)
      G_AND:   return ga & gb;
      G_OR:    return ga | gb;
      G_NAND:  return ~(ga & gb);
      G_NOR:   return ~(ga | gb);
      G_XOR:   return ga ^ gb;
      G_XNOR:  return ~(ga ^ gb);
      default: return 1'b0;
    endcase
  endfunction

  assign y1 = gate_out(gmode, a1, b1);
  assign y3 = gate_out(gmode, a3, b3);

  gate_exerciser #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op_v),
    .a(a1), .b(b1), .y(y1), .busy(busy1), .done(done1), .pass(pass1),
    .bad_op(bad1), .err_count(cnt1), .err_mask(mask1), .state_dbg(st1)
  );

  gate_exerciser #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .op(op_v),
    .a(a3), .b(b3), .y(y3), .busy(busy3), .done(done3), .pass(pass3),
    .bad_op(bad3), .err_count(cnt3), .err_mask(mask3), .state_dbg(st3)
  );

  // Views of whichever instance the current test uses.
  logic       v_a, v_b, v_busy, v_done, v_pass, v_bad;
  logic [2:0] v_cnt;
  logic [3:0] v_mask;
  logic [1:0] v_st;
  assign v_a    = use3 ? a3    : a1;
  assign v_b    = use3 ? b3    : b1;
  assign v_busy = use3 ? busy3 : busy1;
  assign v_done = use3 ? done3 : done1;
  assign v_pass = use3 ? pass3 : pass1;
  assign v_bad  = use3 ? bad3  : bad1;
  assign v_cnt  = use3 ? cnt3  : cnt1;
  assign v_mask = use3 ? mask3 : mask1;
  assign v_st   = use3 ? st3   : st1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset_view(input string tag);
    check({tag, "_state"}, 32'(v_st),   32'd0);
    check({tag, "_ab"},    32'({v_a, v_b}), 32'd0);
    check({tag, "_busy"},  32'(v_busy), 32'd0);
    check({tag, "_done"},  32'(v_done), 32'd0);
    check({tag, "_pass"},  32'(v_pass), 32'd0);
    check({tag, "_bad"},   32'(v_bad),  32'd0);
    check({tag, "_cnt"},   32'(v_cnt),  32'd0);
    check({tag, "_mask"},  32'(v_mask), 32'd0);
  endtask

  // ---------------- driver: one sweep ----------------
  // Called just after an active edge. restart_at (cycles after acceptance)
  // raises start for one cycle at that point; -1 disables it.
  task automatic sweep(input string tag, input logic u3, input logic [2:0] op,
                       input int gm, input logic exp_pass, input logic exp_bad,
                       input int exp_cnt, input logic [3:0] exp_mask,
                       input int restart_at);
    int    s;
    int    cyc;
    int    extra;
    logic  got_done;
    s        = u3 ? 3 : 1;
    use3     = u3;
    gmode    = gm;
    op_v     = op;
    start_v  = 1'b1;
    @(posedge clk) #1;              // acceptance edge E0
    start_v  = 1'b0;
    op_v     = ~op;                 // later op changes must not matter
    cyc      = 0;
    got_done = 1'b0;
    while (cyc < 200 && !got_done) begin
      if (v_done) begin
        got_done = 1'b1;
        check({tag, "_latency"}, 32'(cyc), exp_bad ? 32'd0 : 32'(4 * s));
        check({tag, "_busy_at_done"}, 32'(v_busy), 32'd0);
        check({tag, "_pass"}, 32'(v_pass), 32'(exp_pass));
        check({tag, "_bad"},  32'(v_bad),  32'(exp_bad));
        check({tag, "_cnt"},  32'(v_cnt),  32'(exp_cnt));
        check({tag, "_mask"}, 32'(v_mask), 32'(exp_mask));
        if (exp_bad) check({tag, "_ab_idle"}, 32'({v_a, v_b}), 32'd0);
      end else begin
        check({tag, "_busy"}, 32'(v_busy), 32'd1);
        check({tag, "_ab"}, 32'({v_a, v_b}), 32'(cyc / s));
      end
      start_v = (cyc == restart_at);
      @(posedge clk) #1;
      cyc++;
    end
    start_v = 1'b0;
    if (!got_done) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_done_pulse"}, 32'(v_done), 32'd0);
    check({tag, "_ab_after"},   32'({v_a, v_b}), 32'd0);
    check({tag, "_state_after"}, 32'(v_st), 32'd0);
    check({tag, "_pass_held"},  32'(v_pass), 32'(exp_pass));
    extra = 0;
    for (int i = 0; i < 16; i++) begin
      if (v_done) extra++;
      @(posedge clk) #1;
    end
    check({tag, "_extra_done"}, 32'(extra), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    use3 = 1'b0; check_reset_view("rst1");
    use3 = 1'b1; check_reset_view("rst3");
    rst = 1'b0;
    @(posedge clk) #1;

    sweep("and_ok",   1'b0, 3'd0, G_AND,  1'b1, 1'b0, 0, 4'b0000, -1);
    sweep("or_zero",  1'b0, 3'd1, G_ZERO, 1'b0, 1'b0, 3, 4'b1110, 4);
    sweep("xor_xnor", 1'b0, 3'd4, G_XNOR, 1'b0, 1'b0, 4, 4'b1111, -1);
    sweep("op7",      1'b0, 3'd7, G_AND,  1'b0, 1'b1, 0, 4'b0000, 0);
    sweep("nand_s3",  1'b1, 3'd2, G_NAND, 1'b1, 1'b0, 0, 4'b0000, 5);

    // Reset in the middle of vector 2 of an OR sweep.
    use3    = 1'b0;
    gmode   = G_OR;
    op_v    = 3'd1;
    start_v = 1'b1;
    @(posedge clk) #1;
    start_v = 1'b0;
    cyc = 0;
    while (cyc < 2) begin
      @(posedge clk) #1;
      cyc++;
    end
    check("mid_ab_vec2", 32'({v_a, v_b}), 32'd2);
    check("mid_busy",    32'(v_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk) #1;
    check_reset_view("mid_rst");
    rst = 1'b0;
    @(posedge clk) #1;
    sweep("or_after_rst", 1'b0, 3'd1, G_OR, 1'b1, 1'b0, 0, 4'b0000, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
